// File: rtl/add_pkg.sv
// Shared definitions for the byte-serial wide adder: byte width, controller
// states and the sum-width helper.
package add_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    function automatic int sum_width(input int words);
        return BYTE_W * words + 1;
    endfunction

endpackage

// File: rtl/add8_ci.sv
// 8-bit ripple-carry adder slice with carry-in and carry-out, built as a chain
// of full-adder cells.
module add8_ci
    import add_pkg::*;
(
    input  logic [BYTE_W-1:0] a_i,
    input  logic [BYTE_W-1:0] b_i,
    input  logic              ci_i,
    output logic [BYTE_W-1:0] s_o,
    output logic              co_o
);

    logic [BYTE_W:0] c;

    assign c[0] = ci_i;

    for (genvar i = 0; i < BYTE_W; i++) begin : g_fa
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign co_o = c[BYTE_W];

endmodule

// File: rtl/multi_byte_add_ctrl.sv
// Byte-serial (WORDS*8)-bit unsigned adder: one shared add8_ci slice, LSB byte
// first, carry registered between bytes; valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for an operand pair (in_ready high)
// RUN   | adding byte idx, one byte per clock
// DONE  | sum valid, held until out_ready
module multi_byte_add_ctrl
    import add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BYTE_W*WORDS-1:0]       a,
    input  logic [BYTE_W*WORDS-1:0]       b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [sum_width(WORDS)-1:0]   sum,
    output logic                          busy
);

    localparam int OP_W  = BYTE_W * WORDS;
    localparam int SUM_W = sum_width(WORDS);
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_e             state_q;
    logic [OP_W-1:0]    a_q;
    logic [OP_W-1:0]    b_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic [SUM_W-1:0]   sum_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;

    logic [BYTE_W-1:0]  a_byte;
    logic [BYTE_W-1:0]  b_byte;
    logic [BYTE_W-1:0]  byte_sum_d;
    logic               carry_d;

    assign a_byte = a_q[BYTE_W*idx_q +: BYTE_W];
    assign b_byte = b_q[BYTE_W*idx_q +: BYTE_W];

    add8_ci u_add8 (
        .a_i  (a_byte),
        .b_i  (b_byte),
        .ci_i (carry_q),
        .s_o  (byte_sum_d),
        .co_o (carry_d)
    );

    // in_ready must drop while reset is held, before the register can follow.
    assign in_ready  = in_ready_q & ~rst;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign busy      = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q        <= a;
                        b_q        <= b;
                        idx_q      <= '0;
                        carry_q    <= 1'b0;
                        sum_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    sum_q[BYTE_W*idx_q +: BYTE_W] <= byte_sum_d;
                    carry_q <= carry_d;
                    if (idx_q == LAST_IDX) begin
                        sum_q[SUM_W-1] <= carry_d;
                        idx_q          <= '0;
                        out_valid_q    <= 1'b1;
                        state_q        <= DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
